// File: rtl/truth_table_sweeper.sv
// Stimulus/capture sweeper: walks a 4-input function through all 16 vectors and records f.
// Optional TT_COMPARE_EN adds a first-mismatch detector against EXP_TT.
module truth_table_sweeper #(
   parameter int          HOLD_CYCLES = 4,
   parameter logic [15:0] EXP_TT      = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        f,
   output logic        a,
   output logic        b,
   output logic        c,
   output logic        d,
   output logic [3:0]  vec_idx,
   output logic        busy,
   output logic        done,
   output logic [15:0] tt
`ifdef TT_COMPARE_EN
   ,
   output logic        mismatch,
   output logic [3:0]  mismatch_idx
`endif
);

   // state  | meaning
   // S_IDLE | waiting for start, function inputs parked at 0
   // S_RUN  | presenting vec_q, sampling f on the last cycle of each hold window
   // S_DONE | one-cycle completion pulse, then back to idle
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

   state_t      state_q, state_d;
   logic [3:0]  vec_q, vec_d;
   logic [7:0]  hold_q, hold_d;
   logic [15:0] tt_q, tt_d;
   logic        accept;
   logic        sample;

   assign accept = (state_q == S_IDLE) && start;
   assign sample = (state_q == S_RUN) && (hold_q == HOLD_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         vec_q   <= 4'd0;
         hold_q  <= 8'd0;
         tt_q    <= 16'h0000;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         hold_q  <= hold_d;
         tt_q    <= tt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      hold_d  = hold_q;
      tt_d    = tt_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               vec_d   = 4'd0;
               hold_d  = 8'd0;
               tt_d    = 16'h0000;
            end
         end
         S_RUN: begin
            hold_d = hold_q + 8'd1;
            if (sample) begin
               tt_d[vec_q] = f;
               hold_d      = 8'd0;
               if (vec_q == 4'd15) begin
                  // vec_q returns to 0 here so a..d are already parked during DONE
                  state_d = S_DONE;
                  vec_d   = 4'd0;
               end else begin
                  vec_d = vec_q + 4'd1;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign {a, b, c, d} = vec_q;
   assign vec_idx      = vec_q;
   assign busy         = (state_q == S_RUN);
   assign done         = (state_q == S_DONE);
   assign tt           = tt_q;

`ifdef TT_COMPARE_EN
   logic       mm_q, mm_d;
   logic [3:0] mm_idx_q, mm_idx_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mm_q     <= 1'b0;
         mm_idx_q <= 4'd0;
      end else begin
         mm_q     <= mm_d;
         mm_idx_q <= mm_idx_d;
      end
   end

   always_comb begin
      mm_d     = mm_q;
      mm_idx_d = mm_idx_q;
      if (accept) begin
         mm_d     = 1'b0;
         mm_idx_d = 4'd0;
      end else if (sample && (f != EXP_TT[vec_q]) && !mm_q) begin
         mm_d     = 1'b1;
         mm_idx_d = vec_q;
      end
   end

   assign mismatch     = mm_q;
   assign mismatch_idx = mm_idx_q;
`else
   logic unused_cfg;
   assign unused_cfg = ^{EXP_TT, accept};
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: one instance with 4-clock holds, one with 2-clock holds.
module tb_truth_table_sweeper;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start4 = 1'b0, start2 = 1'b0;
   logic        f4, f2;
   int          mode4 = 0, mode2 = 0;
   logic        a4, b4, c4, d4, busy4, done4;
   logic        a2, b2, c2, d2, busy2, done2;
   logic [3:0]  vec4, vec2;
   logic [15:0] tt4, tt2;
`ifdef TT_COMPARE_EN
   logic        mm4, mm2;
   logic [3:0]  midx4, midx2;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // 0: constant 0, 1: constant 1, 2: a^b^c^d, 3: a^b^c
   function automatic logic fn(input int m, input logic [3:0] v);
      case (m)
         0:       fn = 1'b0;
         1:       fn = 1'b1;
         2:       fn = ^v;
         default: fn = ^v[3:1];
      endcase
   endfunction

   always_comb f4 = fn(mode4, {a4, b4, c4, d4});
   always_comb f2 = fn(mode2, {a2, b2, c2, d2});

   truth_table_sweeper #(.HOLD_CYCLES(4), .EXP_TT(16'h6996)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .f(f4),
      .a(a4), .b(b4), .c(c4), .d(d4), .vec_idx(vec4),
      .busy(busy4), .done(done4), .tt(tt4)
`ifdef TT_COMPARE_EN
      , .mismatch(mm4), .mismatch_idx(midx4)
`endif
   );

   truth_table_sweeper #(.HOLD_CYCLES(2), .EXP_TT(16'h6996)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .f(f2),
      .a(a2), .b(b2), .c(c2), .d(d2), .vec_idx(vec2),
      .busy(busy2), .done(done2), .tt(tt2)
`ifdef TT_COMPARE_EN
      , .mismatch(mm2), .mismatch_idx(midx2)
`endif
   );

   // start is raised at a negedge and dropped just after the accepting edge E0
   task automatic kick(input int sel);
      @(negedge clk);
      if (sel == 4) start4 = 1'b1; else start2 = 1'b1;
      @(posedge clk);
      #1;
      if (sel == 4) start4 = 1'b0; else start2 = 1'b0;
   endtask

   // returns at the negedge where done is first seen
   task automatic wait_done(input int sel, output int busy_cnt, output bit timed_out);
      busy_cnt  = 0;
      timed_out = 1'b1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if ((sel == 4) ? busy4 : busy2) busy_cnt++;
         if ((sel == 4) ? done4 : done2) begin
            timed_out = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset;
      #12;
      n_cmp++;
      if ({a4, b4, c4, d4, vec4, busy4, done4, tt4} !== 26'd0) begin
         n_err++;
         $display("FAIL reset4: got abcd=%b vec=%0d busy=%b done=%b tt=%h, want all 0", {a4, b4, c4, d4}, vec4, busy4, done4, tt4);
      end
      n_cmp++;
      if ({a2, b2, c2, d2, vec2, busy2, done2, tt2} !== 26'd0) begin
         n_err++;
         $display("FAIL reset2: got abcd=%b vec=%0d busy=%b done=%b tt=%h, want all 0", {a2, b2, c2, d2}, vec2, busy2, done2, tt2);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_parity_sweep;
      int bc;
      bit to;
      mode4 = 2;
      kick(4);
      wait_done(4, bc, to);
      n_cmp++;
      if (to || bc != 64) begin
         n_err++;
         $display("FAIL parity_busy: got %0d busy cycles (timeout=%0d), want 64", bc, to);
      end
      n_cmp++;
      if (tt4 !== 16'h6996 || busy4 !== 1'b0) begin
         n_err++;
         $display("FAIL parity_tt: got tt=%h busy=%b, want tt=6996 busy=0", tt4, busy4);
      end
      @(negedge clk);
      n_cmp++;
      if (done4 !== 1'b0) begin
         n_err++;
         $display("FAIL parity_done_pulse: got done=%b one cycle later, want 0", done4);
      end
   endtask

   task automatic test_constant_and_hold;
      int bc;
      bit to;
      mode4 = 0;
      kick(4);
      @(negedge clk);
      n_cmp++;
      if (tt4 !== 16'h0000) begin
         n_err++;
         $display("FAIL tt_cleared_on_start: got %h, want 0000", tt4);
      end
      wait_done(4, bc, to);
      n_cmp++;
      if (to || tt4 !== 16'h0000) begin
         n_err++;
         $display("FAIL const0_tt: got %h (timeout=%0d), want 0000", tt4, to);
      end
      mode4 = 1;
      repeat (10) @(negedge clk);
      n_cmp++;
      if (tt4 !== 16'h0000 || busy4 !== 1'b0) begin
         n_err++;
         $display("FAIL tt_held_idle: got tt=%h busy=%b, want 0000 and 0", tt4, busy4);
      end
      kick(4);
      wait_done(4, bc, to);
      n_cmp++;
      if (to || tt4 !== 16'hFFFF) begin
         n_err++;
         $display("FAIL const1_tt: got %h (timeout=%0d), want FFFF", tt4, to);
      end
   endtask

   task automatic test_timing_hold2;
      int bad_j;
      logic [3:0] got_v, got_abcd;
      mode2 = 2;
      bad_j = -1;
      got_v = 4'd0;
      got_abcd = 4'd0;
      kick(2);
      for (int j = 0; j < 32; j++) begin
         @(negedge clk);
         if (bad_j < 0 && (vec2 !== 4'(j / 2) || {a2, b2, c2, d2} !== 4'(j / 2) || busy2 !== 1'b1)) begin
            bad_j = j;
            got_v = vec2;
            got_abcd = {a2, b2, c2, d2};
         end
      end
      n_cmp++;
      if (bad_j >= 0) begin
         n_err++;
         $display("FAIL step_hold2: cycle %0d got vec=%0d abcd=%b, want %0d", bad_j, got_v, got_abcd, bad_j / 2);
      end
      @(negedge clk);
      n_cmp++;
      if (done2 !== 1'b1 || busy2 !== 1'b0 || {a2, b2, c2, d2} !== 4'd0 || vec2 !== 4'd0) begin
         n_err++;
         $display("FAIL done_hold2: got done=%b busy=%b abcd=%b vec=%0d, want 1 0 0000 0", done2, busy2, {a2, b2, c2, d2}, vec2);
      end
      @(negedge clk);
      n_cmp++;
      if (done2 !== 1'b0 || tt2 !== 16'h6996) begin
         n_err++;
         $display("FAIL after_done_hold2: got done=%b tt=%h, want 0 6996", done2, tt2);
      end
   endtask

   task automatic test_ignore_start;
      int bc, dc;
      bit seen5, pulsed;
      mode4 = 2;
      bc = 0; dc = 0; seen5 = 0; pulsed = 0;
      kick(4);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (busy4) bc++;
         if (done4) dc++;
         if (!pulsed && vec4 == 4'd5) begin
            seen5 = 1;
            start4 = 1'b1;
         end else if (seen5 && !pulsed) begin
            start4 = 1'b0;
            pulsed = 1;
         end
      end
      n_cmp++;
      if (bc != 64 || dc != 1 || !pulsed) begin
         n_err++;
         $display("FAIL ignore_start: got busy=%0d done_pulses=%0d pulsed=%0d, want 64 1 1", bc, dc, pulsed);
      end
      n_cmp++;
      if (tt4 !== 16'h6996) begin
         n_err++;
         $display("FAIL ignore_start_tt: got %h, want 6996", tt4);
      end
   endtask

   task automatic test_reset_mid;
      int bc;
      bit to, reached, spurious;
      mode4 = 2;
      reached = 0;
      kick(4);
      for (int i = 0; i < 100 && !reached; i++) begin
         @(negedge clk);
         if (vec4 == 4'd7) reached = 1;
      end
      n_cmp++;
      if (!reached || tt4 !== 16'h0016) begin
         n_err++;
         $display("FAIL partial_tt_at_7: got tt=%h reached=%0d, want 0016 1", tt4, reached);
      end
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if ({a4, b4, c4, d4, vec4, busy4, done4, tt4} !== 26'd0) begin
         n_err++;
         $display("FAIL async_reset_mid: got abcd=%b vec=%0d busy=%b done=%b tt=%h, want all 0", {a4, b4, c4, d4}, vec4, busy4, done4, tt4);
      end
      @(negedge clk);
      rst = 1'b0;
      spurious = 0;
      repeat (10) begin
         @(negedge clk);
         if (done4 || busy4) spurious = 1;
      end
      n_cmp++;
      if (spurious) begin
         n_err++;
         $display("FAIL post_reset_quiet: got done/busy activity=%0d, want 0", spurious);
      end
      kick(4);
      wait_done(4, bc, to);
      n_cmp++;
      if (to || bc != 64 || tt4 !== 16'h6996) begin
         n_err++;
         $display("FAIL sweep_after_reset: got busy=%0d tt=%h timeout=%0d, want 64 6996 0", bc, tt4, to);
      end
   endtask

   task automatic test_back_to_back;
      int bc;
      bit to;
      mode2 = 2;
      @(negedge clk);
      start2 = 1'b1;
      wait_done(2, bc, to);
      n_cmp++;
      if (to || bc != 32) begin
         n_err++;
         $display("FAIL b2b_first: got busy=%0d timeout=%0d, want 32 0", bc, to);
      end
      @(negedge clk);
      n_cmp++;
      if (busy2 !== 1'b0 || done2 !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_idle_gap: got busy=%b done=%b, want 0 0", busy2, done2);
      end
      @(negedge clk);
      n_cmp++;
      if (busy2 !== 1'b1 || vec2 !== 4'd0) begin
         n_err++;
         $display("FAIL b2b_restart: got busy=%b vec=%0d, want 1 0", busy2, vec2);
      end
      start2 = 1'b0;
      wait_done(2, bc, to);
      n_cmp++;
      if (to || bc != 31 || tt2 !== 16'h6996) begin
         n_err++;
         $display("FAIL b2b_second: got busy=%0d tt=%h timeout=%0d, want 31 6996 0", bc, tt2, to);
      end
   endtask

`ifdef TT_COMPARE_EN
   task automatic test_compare;
      int bc;
      bit to;
      mode4 = 3;
      kick(4);
      wait_done(4, bc, to);
      n_cmp++;
      if (to || mm4 !== 1'b1 || midx4 !== 4'd1) begin
         n_err++;
         $display("FAIL compare_xor3: got mismatch=%b idx=%0d timeout=%0d, want 1 1 0", mm4, midx4, to);
      end
      mode4 = 2;
      kick(4);
      wait_done(4, bc, to);
      n_cmp++;
      if (to || mm4 !== 1'b0 || midx4 !== 4'd0) begin
         n_err++;
         $display("FAIL compare_xor4: got mismatch=%b idx=%0d timeout=%0d, want 0 0 0", mm4, midx4, to);
      end
   endtask
`endif

   initial begin
      test_reset;
      test_parity_sweep;
      test_constant_and_hold;
      test_timing_hold2;
      test_ignore_start;
      test_reset_mid;
      test_back_to_back;
`ifdef TT_COMPARE_EN
      test_compare;
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
